sevenseg_scan_decoder: RTL and testbench
========================================

Name: sevenseg_scan_decoder

Overview:
- Receive-side counterpart to the team's multiplexed seven-segment drivers.
- Samples the active-low segment bus and the anode lines, and recovers the hex value shown on each digit position.
- Requires a configurable stability window before it accepts a value.
- Used for on-board loopback checking of display drivers and as a bench monitor. It sits beside the display driver on the same CLK100MHZ domain.

Parameters:
- NUM_DIGITS, 8: number of anode lines and digit positions (1..8).
- STABLE_CYCLES, 4: consecutive identical samples required before a value is accepted (2..255).

Ports:
- CLK100MHZ  input  1  system clock.
- CPU_RESETN  input  1  synchronous active-low reset.
- HEX  input  [0:6]  active-low segments. HEX[0]=a through HEX[6]=g.
- AN  input  NUM_DIGITS  active-low anode enables.
- DIGITS  output  4*NUM_DIGITS  recovered nibbles. Digit i is in bits [4i+3:4i].
- DIGIT_VALID  output  NUM_DIGITS  digit i holds an accepted, non-blank value.
- UPDATE  output  1  one-cycle pulse when a digit is written.
- UPDATE_IDX  output  3  index of the digit written. Meaningful only while UPDATE=1.
- ERR_PATTERN  output  1  sticky: an accepted pattern was not a hex glyph.
- ERR_MULTI_AN  output  1  one-cycle pulse: more than one anode was low in a sample.

Behaviour:
- Reset: CPU_RESETN=0 at an edge clears all outputs, the sample registers and the stability counter on that edge. Reset has priority over every other event.
- Input stage: HEX and AN are registered once. All decisions use the registered copy.
- Sample classification:
  - Exactly one AN bit low: active sample with idx equal to that bit.
  - No AN bit low: idle sample. Counter is cleared; no update.
  - Two or more AN bits low: ERR_MULTI_AN pulses for the next cycle; counter is cleared; no update.
- Stability counter:
  - An active sample equal to the previous sample in both idx and HEX increments the counter, saturating at STABLE_CYCLES.
  - Any other active sample loads 1.
  - The accept event fires only on the transition to STABLE_CYCLES, so it occurs once per stable run.
- Timing: with inputs stable from edge E, the registered sample appears at E+1. UPDATE is high for exactly one cycle after edge E+STABLE_CYCLES+1. Outputs are registered.
- Accept action, by pattern (segments a..g, 0 = lit):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Hex glyph: write DIGITS[idx], set DIGIT_VALID[idx], pulse UPDATE with UPDATE_IDX=idx.
  - Blank (1111111): clear DIGIT_VALID[idx]. DIGITS[idx] is unchanged; no UPDATE, no error.
  - Any other pattern: set ERR_PATTERN (held until reset). DIGITS and DIGIT_VALID are unchanged; no UPDATE.
- Idle samples from inter-digit blanking never alter stored digits.
- Rewriting the same value still pulses UPDATE once per new stable run.
- Holding one digit indefinitely produces exactly one UPDATE.

Optional Feature:
- Macro: SEVENSEG_DP_EN.
- Defined:
  - Adds input DP (1, active-low decimal point) and output DIGIT_DP (NUM_DIGITS).
  - DP joins HEX in the stability comparison.
  - On a hex-glyph or blank accept, DIGIT_DP[idx] is set to the inverted DP. It is cleared on reset.
- Undefined: no DP/DIGIT_DP ports, and no DP logic is present.

Test Plan:
- Reset held 3 cycles, then released with AN=8'hFF -> all outputs 0; no UPDATE for 20 cycles.
- AN=8'hFE, HEX=0010010 held 10 cycles, STABLE_CYCLES=4 -> single UPDATE after edge E+5, UPDATE_IDX=0, DIGITS[3:0]=2, DIGIT_VALID=8'h01.
- Scan of digits 0..3 showing 1,A,C,F, each held 6 cycles and separated by 2 idle cycles -> four UPDATEs in order with idx 0..3; DIGITS[15:0]=16'hFCA1; DIGIT_VALID=8'h0F.
- AN=8'hFD with HEX toggling 0000110/0000100 every 2 cycles (STABLE_CYCLES=4) -> no UPDATE; then AN=8'hFC for 1 cycle -> ERR_MULTI_AN pulses once.
- Accepted HEX=1111110 on digit 2 -> ERR_PATTERN=1 and stays high. A later accepted blank on digit 0 -> DIGIT_VALID[0]=0 and ERR_PATTERN still 1.
- Reset asserted while counter=3 -> outputs cleared next edge. After release, an identical held digit needs a full STABLE_CYCLES+1 again before UPDATE.

Source files
------------

// File: rtl/sevenseg_scan_decoder.sv
// rtl/sevenseg_scan_decoder.sv - recovers hex digits from a multiplexed active-low seven-segment bus
// Optional decimal-point capture is enabled with SEVENSEG_DP_EN.
module sevenseg_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    CLK100MHZ,
  input  logic                    CPU_RESETN,
  input  logic [0:6]              HEX,
  input  logic [NUM_DIGITS-1:0]   AN,
`ifdef SEVENSEG_DP_EN
  input  logic                    DP,
  output logic [NUM_DIGITS-1:0]   DIGIT_DP,
`endif
  output logic [4*NUM_DIGITS-1:0] DIGITS,
  output logic [NUM_DIGITS-1:0]   DIGIT_VALID,
  output logic                    UPDATE,
  output logic [2:0]              UPDATE_IDX,
  output logic                    ERR_PATTERN,
  output logic                    ERR_MULTI_AN
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [0:6]            hex_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [0:6]            prev_hex;
  logic [NUM_DIGITS-1:0] prev_an;
  logic [7:0]            cnt;
`ifdef SEVENSEG_DP_EN
  logic                  dp_q;
  logic                  prev_dp;
`endif

  logic [3:0] low_cnt;
  logic [2:0] act_idx;
  logic       same;
  logic       is_glyph;
  logic       is_blank;
  logic [3:0] nib;

  always_comb begin
    low_cnt = 4'd0;
    act_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        low_cnt = low_cnt + 4'd1;
        act_idx = 3'(i);
      end
    end
  end

  // A run continues only while both the anode pattern and the segments repeat exactly.
  always_comb begin
    same = (hex_q == prev_hex) && (an_q == prev_an);
`ifdef SEVENSEG_DP_EN
    same = same && (dp_q == prev_dp);
`endif
  end

  always_comb begin
    is_glyph = 1'b1;
    is_blank = 1'b0;
    nib      = 4'h0;
    case (hex_q)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      7'b1111111: begin
        is_glyph = 1'b0;
        is_blank = 1'b1;
      end
      default: is_glyph = 1'b0;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      hex_q        <= '1;
      an_q         <= '1;
      prev_hex     <= '1;
      prev_an      <= '1;
      cnt          <= 8'd0;
      DIGITS       <= '0;
      DIGIT_VALID  <= '0;
      UPDATE       <= 1'b0;
      UPDATE_IDX   <= 3'd0;
      ERR_PATTERN  <= 1'b0;
      ERR_MULTI_AN <= 1'b0;
`ifdef SEVENSEG_DP_EN
      dp_q         <= 1'b1;
      prev_dp      <= 1'b1;
      DIGIT_DP     <= '0;
`endif
    end else begin
      hex_q        <= HEX;
      an_q         <= AN;
      prev_hex     <= hex_q;
      prev_an      <= an_q;
      UPDATE       <= 1'b0;
      ERR_MULTI_AN <= 1'b0;
`ifdef SEVENSEG_DP_EN
      dp_q         <= DP;
      prev_dp      <= dp_q;
`endif
      if (low_cnt == 4'd0) begin
        cnt <= 8'd0;
      end else if (low_cnt != 4'd1) begin
        cnt          <= 8'd0;
        ERR_MULTI_AN <= 1'b1;
      end else if (!same) begin
        cnt <= 8'd1;
      end else if (cnt != STABLE) begin
        cnt <= cnt + 8'd1;
        // Accept only on the step into STABLE so a held digit fires once.
        if (cnt == STABLE - 8'd1) begin
          if (is_glyph) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (3'(i) == act_idx) begin
                DIGITS[4*i +: 4] <= nib;
                DIGIT_VALID[i]   <= 1'b1;
              end
            end
            UPDATE     <= 1'b1;
            UPDATE_IDX <= act_idx;
          end else if (is_blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (3'(i) == act_idx) DIGIT_VALID[i] <= 1'b0;
            end
          end else begin
            ERR_PATTERN <= 1'b1;
          end
`ifdef SEVENSEG_DP_EN
          if (is_glyph || is_blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (3'(i) == act_idx) DIGIT_DP[i] <= ~dp_q;
            end
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb/tb_sevenseg_scan_decoder.sv - directed self-checking bench for sevenseg_scan_decoder
module tb_sevenseg_scan_decoder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [0:6]  hex = 7'b1111111;
  logic [7:0]  an = 8'hFF;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        update;
  logic [2:0]  update_idx;
  logic        err_pattern;
  logic        err_multi_an;
`ifdef SEVENSEG_DP_EN
  logic        dp = 1'b1;
  logic [7:0]  digit_dp;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int upd_count;
  int upd_first;
  int multi_count;
  int cyc;
  logic [2:0] idx_log [$];

  always #5 clk = ~clk;

  sevenseg_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (resetn),
    .HEX         (hex),
    .AN          (an),
`ifdef SEVENSEG_DP_EN
    .DP          (dp),
    .DIGIT_DP    (digit_dp),
`endif
    .DIGITS      (digits),
    .DIGIT_VALID (digit_valid),
    .UPDATE      (update),
    .UPDATE_IDX  (update_idx),
    .ERR_PATTERN (err_pattern),
    .ERR_MULTI_AN(err_multi_an)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    upd_count   = 0;
    upd_first   = -1;
    multi_count = 0;
    cyc         = 0;
    idx_log.delete();
  endtask

  // Advance one edge and sample 1 time unit later, logging pulses.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (update) begin
      upd_count++;
      if (upd_first < 0) upd_first = cyc;
      idx_log.push_back(update_idx);
    end
    if (err_multi_an) multi_count++;
  endtask

  task automatic hold(input logic [7:0] a, input logic [6:0] h, input int n);
    an  = a;
    hex = h;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    clr();
    resetn = 1'b0;
    for (int k = 0; k < 3; k++) step();
    resetn = 1'b1;
    step();
    check("rst_digits", digits, 32'h0);
    check("rst_valid", {24'h0, digit_valid}, 32'h0);
    check("rst_errs", {29'h0, update, err_pattern, err_multi_an}, 32'h0);
    clr();
    for (int k = 0; k < 20; k++) step();
    check("idle_no_update", upd_count, 0);
    check("idle_no_multi", multi_count, 0);

    // Single digit 2 on position 0, held 10 cycles.
    clr();
    hold(8'hFE, 7'b0010010, 10);
    check("d2_count", upd_count, 1);
    check("d2_edge", upd_first, 5);
    check("d2_idx", (idx_log.size() > 0) ? idx_log[0] : 3'd7, 0);
    check("d2_nibble", digits[3:0], 4'h2);
    check("d2_valid", digit_valid, 8'h01);

    // Scan 1,A,C,F across digits 0..3 with blanking gaps.
    clr();
    hold(8'hFE, 7'b1001111, 6);  hold(8'hFF, 7'b1111111, 2);
    hold(8'hFD, 7'b0001000, 6);  hold(8'hFF, 7'b1111111, 2);
    hold(8'hFB, 7'b0110001, 6);  hold(8'hFF, 7'b1111111, 2);
    hold(8'hF7, 7'b0111000, 6);  hold(8'hFF, 7'b1111111, 2);
    check("scan_count", upd_count, 4);
    for (int i = 0; i < 4; i++)
      check("scan_idx", (idx_log.size() > i) ? idx_log[i] : 3'd7, i);
    check("scan_digits", digits[15:0], 16'hFCA1);
    check("scan_valid", digit_valid, 8'h0F);

    // Segments never settle long enough: no accept. Then one multi-anode sample.
    clr();
    for (int k = 0; k < 4; k++) begin
      hold(8'hFD, 7'b0000110, 2);
      hold(8'hFD, 7'b0000100, 2);
    end
    check("toggle_no_update", upd_count, 0);
    check("toggle_digits", digits[15:0], 16'hFCA1);
    clr();
    hold(8'hFC, 7'b0000110, 1);
    hold(8'hFF, 7'b1111111, 4);
    check("multi_once", multi_count, 1);
    check("multi_no_update", upd_count, 0);

    // Non-glyph pattern then a blank accept.
    clr();
    hold(8'hFB, 7'b1111110, 6);
    check("badpat_err", err_pattern, 1);
    check("badpat_valid", digit_valid, 8'h0F);
    check("badpat_digits", digits[15:0], 16'hFCA1);
    hold(8'hFF, 7'b1111111, 2);
    hold(8'hFE, 7'b1111111, 6);
    check("blank_valid", digit_valid, 8'h0E);
    check("blank_digit_kept", digits[3:0], 4'h1);
    check("blank_err_sticky", err_pattern, 1);
    check("badpat_blank_no_update", upd_count, 0);

    // Reset while the counter sits at 3, then a full window is needed again.
    clr();
    hold(8'hFD, 7'b0000110, 4);
    check("pre_rst_no_update", upd_count, 0);
    resetn = 1'b0;
    step();
    check("mid_rst_digits", digits, 32'h0);
    check("mid_rst_valid", digit_valid, 8'h00);
    check("mid_rst_err", err_pattern, 0);
    resetn = 1'b1;
    clr();
    for (int k = 0; k < 12; k++) step();
    check("post_rst_count", upd_count, 1);
    check("post_rst_edge", upd_first, 5);
    check("post_rst_digit", digits[7:4], 4'h3);
    check("post_rst_valid", digit_valid, 8'h02);

    // Same value again after a gap pulses once more.
    clr();
    hold(8'hFF, 7'b1111111, 2);
    hold(8'hFD, 7'b0000110, 8);
    check("rewrite_count", upd_count, 1);
    check("rewrite_idx", (idx_log.size() > 0) ? idx_log[0] : 3'd7, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
